video_timing_gen: RTL and testbench

Pixel-clock video timing generator that sits directly upstream of the RGB-to-HDMI converter. It produces the blk/hs/vs control signals the converter encodes into TMDS.
It also exposes raw pixel counters and line/frame strobes so the GPU pixel fetch pipeline can address VRAM ahead of the output.
A configurable delay line aligns blk/hs/vs with the fetch pipeline latency, so RGB data and control arrive at the converter on the same clkRGB edge.

---
 rtl/video_timing_gen_if.sv | 26 ++
 rtl/video_timing_gen.sv | 116 +++++++++++
 tb/tb_video_timing_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Timing bundle between video_timing_gen (master) and its consumers (slave):
// run/stop control in, counters, strobes and converter controls out.
interface video_timing_gen_if;
  logic        enable;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        activeEarly;
  logic        lineStart;
  logic        frameStart;
  logic        blk;
  logic        hs;
  logic        vs;
`ifdef VIDEO_TIMING_FRAMECOUNT_EN
  logic [15:0] frameCount;

  modport master (input enable, output hcount, vcount, activeEarly, lineStart,
                  frameStart, blk, hs, vs, frameCount);
  modport slave  (output enable, input hcount, vcount, activeEarly, lineStart,
                  frameStart, blk, hs, vs, frameCount);
`else
  modport master (input enable, output hcount, vcount, activeEarly, lineStart,
                  frameStart, blk, hs, vs);
  modport slave  (output enable, input hcount, vcount, activeEarly, lineStart,
                  frameStart, blk, hs, vs);
`endif
endinterface

// File: rtl/video_timing_gen.sv
// Pixel-clock timing generator: raw counters/strobes for the fetch pipeline plus
// blk/hs/vs delayed PIPE_DELAY cycles. VIDEO_TIMING_FRAMECOUNT_EN adds frameCount.
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = 2
) (
  input  logic               clkRGB,
  input  logic               resetn,
  video_timing_gen_if.master vt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_FRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] VS_FRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic blk;
    logic hs;
    logic vs;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{blk: 1'b1, hs: ~HS_POL, vs: ~VS_POL};

  logic [11:0] hcnt, vcnt;
  logic        run, act, line_start, frame_start;
  ctl_t        ctl_raw, ctl_out;

  // Decode is gated by reset too so the combinational outputs read idle while held.
  assign run = vt.enable & resetn;

  always_ff @(posedge clkRGB or negedge resetn) begin
    if (!resetn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!vt.enable) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 12'd1;
    end else begin
      hcnt <= hcnt + 12'd1;
    end
  end

  always_comb begin
    act         = run && (hcnt < H_ACT) && (vcnt < V_ACT);
    line_start  = run && (hcnt == '0);
    frame_start = line_start && (vcnt == '0);
    ctl_raw     = CTL_IDLE;
    if (run) begin
      ctl_raw.blk = ~act;
      if (hcnt >= HS_FRST && hcnt <= HS_LAST) ctl_raw.hs = HS_POL;
      if (vcnt >= VS_FRST && vcnt <= VS_LAST) ctl_raw.vs = VS_POL;
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign ctl_out = ctl_raw;
    end else begin : g_dly
      ctl_t [PIPE_DELAY-1:0] ctl_q;

      // Stopping flushes every stage so no stale sync pulse survives a restart.
      always_ff @(posedge clkRGB or negedge resetn) begin
        if (!resetn) begin
          ctl_q <= {PIPE_DELAY{CTL_IDLE}};
        end else if (!vt.enable) begin
          ctl_q <= {PIPE_DELAY{CTL_IDLE}};
        end else begin
          ctl_q[0] <= ctl_raw;
          for (int i = 1; i < PIPE_DELAY; i++) ctl_q[i] <= ctl_q[i-1];
        end
      end

      assign ctl_out = ctl_q[PIPE_DELAY-1];
    end
  endgenerate

`ifdef VIDEO_TIMING_FRAMECOUNT_EN
  logic [15:0] fcnt;

  always_ff @(posedge clkRGB or negedge resetn) begin
    if (!resetn)            fcnt <= '0;
    else if (!vt.enable)    fcnt <= '0;
    else if (frame_start)   fcnt <= fcnt + 16'd1;
  end

  assign vt.frameCount = fcnt;
`endif

  assign vt.hcount      = hcnt;
  assign vt.vcount      = vcnt;
  assign vt.activeEarly = act;
  assign vt.lineStart   = line_start;
  assign vt.frameStart  = frame_start;
  assign vt.blk         = ctl_out.blk;
  assign vt.hs          = ctl_out.hs;
  assign vt.vs          = ctl_out.vs;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: default-timing instance checked from a cycle table; two shrunken-timing
// instances (PIPE_DELAY 0 and 2, opposite polarities) tracked every cycle by a model.
module tb_video_timing_gen;
  localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 2, SHT = SHA + SHF + SHS + SHB;
  localparam int SVA = 8,  SVF = 2, SVS = 2, SVB = 3, SVT = SVA + SVF + SVS + SVB;
  localparam int SFRAME = SHT * SVT;

  logic clkRGB = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b1;
  always #5 clkRGB = ~clkRGB;

  int n_cmp = 0;
  int n_bad = 0;

  video_timing_gen_if if_d ();
  video_timing_gen_if if_0 ();
  video_timing_gen_if if_2 ();
  assign if_d.enable = enable;
  assign if_0.enable = enable;
  assign if_2.enable = enable;

  video_timing_gen #(.PIPE_DELAY(0)) u_def (.clkRGB(clkRGB), .resetn(resetn), .vt(if_d));

  video_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(0)
  ) u_s0 (.clkRGB(clkRGB), .resetn(resetn), .vt(if_0));

  video_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(2)
  ) u_s2 (.clkRGB(clkRGB), .resetn(resetn), .vt(if_2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic blk;
    logic hs;
    logic vs;
  } ctl_t;

  localparam ctl_t IDLE2 = '{blk: 1'b1, hs: 1'b0, vs: 1'b0};

  // Expected converter controls for the shrunken timing at a given position.
  function automatic ctl_t dec(int h, int v, bit run, bit hp, bit vp);
    ctl_t c;
    c.blk = !(run && h < SHA && v < SVA);
    c.hs  = (run && h >= SHA + SHF && h < SHA + SHF + SHS) ? hp : !hp;
    c.vs  = (run && v >= SVA + SVF && v < SVA + SVF + SVS) ? vp : !vp;
    return c;
  endfunction

  // Model state: counters, frame count and the expected contents of u_s2's delay line.
  int   mh = 0, mv = 0, mfc = 0;
  ctl_t q2[$];
  bit   chk_on = 1'b0;

  always @(negedge clkRGB) begin : model
    bit   run;
    ctl_t e0;
    if (chk_on) begin
      if (!resetn) begin
        mh = 0; mv = 0; mfc = 0;
        q2 = '{IDLE2, IDLE2};
      end
      run = resetn && enable;
      e0  = dec(mh, mv, run, 1'b0, 1'b0);
      chk("s0.hcount", 32'(if_0.hcount), 32'(mh));
      chk("s0.vcount", 32'(if_0.vcount), 32'(mv));
      chk("s0.activeEarly", 32'(if_0.activeEarly), 32'(run && mh < SHA && mv < SVA));
      chk("s0.lineStart", 32'(if_0.lineStart), 32'(run && mh == 0));
      chk("s0.frameStart", 32'(if_0.frameStart), 32'(run && mh == 0 && mv == 0));
      chk("s0.blk", 32'(if_0.blk), 32'(e0.blk));
      chk("s0.hs", 32'(if_0.hs), 32'(e0.hs));
      chk("s0.vs", 32'(if_0.vs), 32'(e0.vs));
      chk("s2.hcount", 32'(if_2.hcount), 32'(mh));
      chk("s2.blk", 32'(if_2.blk), 32'(q2[0].blk));
      chk("s2.hs", 32'(if_2.hs), 32'(q2[0].hs));
      chk("s2.vs", 32'(if_2.vs), 32'(q2[0].vs));
`ifdef VIDEO_TIMING_FRAMECOUNT_EN
      chk("s0.frameCount", 32'(if_0.frameCount), 32'(mfc));
`endif
      // Advance to the state the next rising edge produces.
      if (resetn) begin
        if (!enable) begin
          mh = 0; mv = 0; mfc = 0;
          q2 = '{IDLE2, IDLE2};
        end else begin
          if (mh == 0 && mv == 0) mfc = (mfc + 1) & 16'hFFFF;
          q2.push_back(dec(mh, mv, 1'b1, 1'b1, 1'b1));
          void'(q2.pop_front());
          mh++;
          if (mh == SHT) begin
            mh = 0;
            mv++;
            if (mv == SVT) mv = 0;
          end
        end
      end
    end
  end

  typedef struct {
    int cyc;
    int h;
    int v;
    bit act;
    bit ls;
    bit fs;
    bit blk;
    bit hs;
  } vec_t;

  vec_t tv[12];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int cyc, guard, hs_low, ls_cnt, vs0_cnt, vs2_cnt;
    tv[0]  = '{0,    0,   0, 1, 1, 1, 0, 1};
    tv[1]  = '{1,    1,   0, 1, 0, 0, 0, 1};
    tv[2]  = '{639,  639, 0, 1, 0, 0, 0, 1};
    tv[3]  = '{640,  640, 0, 0, 0, 0, 1, 1};
    tv[4]  = '{655,  655, 0, 0, 0, 0, 1, 1};
    tv[5]  = '{656,  656, 0, 0, 0, 0, 1, 0};
    tv[6]  = '{751,  751, 0, 0, 0, 0, 1, 0};
    tv[7]  = '{752,  752, 0, 0, 0, 0, 1, 1};
    tv[8]  = '{799,  799, 0, 0, 0, 0, 1, 1};
    tv[9]  = '{800,  0,   1, 1, 1, 0, 0, 1};
    tv[10] = '{1599, 799, 1, 0, 0, 0, 1, 1};
    tv[11] = '{1600, 0,   2, 1, 1, 0, 0, 1};

    q2 = '{IDLE2, IDLE2};
    repeat (3) @(negedge clkRGB);
    chk("rst.hcount", 32'(if_d.hcount), 0);
    chk("rst.vcount", 32'(if_d.vcount), 0);
    chk("rst.activeEarly", 32'(if_d.activeEarly), 0);
    chk("rst.lineStart", 32'(if_d.lineStart), 0);
    chk("rst.frameStart", 32'(if_d.frameStart), 0);
    chk("rst.blk", 32'(if_d.blk), 1);
    chk("rst.hs", 32'(if_d.hs), 1);
    chk("rst.vs", 32'(if_d.vs), 1);
    chk("rst.s2.hs", 32'(if_2.hs), 0);
    chk("rst.s2.vs", 32'(if_2.vs), 0);
    chk_on = 1'b1;

    @(posedge clkRGB); #2 resetn = 1'b1;
    @(negedge clkRGB);
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      while (cyc < tv[i].cyc) begin
        @(negedge clkRGB);
        cyc++;
      end
      chk($sformatf("tv%0d.hcount", i), 32'(if_d.hcount), 32'(tv[i].h));
      chk($sformatf("tv%0d.vcount", i), 32'(if_d.vcount), 32'(tv[i].v));
      chk($sformatf("tv%0d.activeEarly", i), 32'(if_d.activeEarly), 32'(tv[i].act));
      chk($sformatf("tv%0d.lineStart", i), 32'(if_d.lineStart), 32'(tv[i].ls));
      chk($sformatf("tv%0d.frameStart", i), 32'(if_d.frameStart), 32'(tv[i].fs));
      chk($sformatf("tv%0d.blk", i), 32'(if_d.blk), 32'(tv[i].blk));
      chk($sformatf("tv%0d.hs", i), 32'(if_d.hs), 32'(tv[i].hs));
    end

    // One full default line: hs width and strobe count; one small frame of vs.
    hs_low = 0; ls_cnt = 0; vs0_cnt = 0; vs2_cnt = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clkRGB);
      if (if_d.hs == 1'b0) hs_low++;
      if (if_d.lineStart) ls_cnt++;
      if (k < SFRAME) begin
        if (if_0.vs == 1'b0) vs0_cnt++;
        if (if_2.vs == 1'b1) vs2_cnt++;
      end
    end
    chk("line.hs_low_cycles", 32'(hs_low), 96);
    chk("line.lineStart_count", 32'(ls_cnt), 1);
    chk("frame.s0_vs_cycles", 32'(vs0_cnt), 32'(SVS * SHT));
    chk("frame.s2_vs_cycles", 32'(vs2_cnt), 32'(SVS * SHT));

    // Stop during hs, hold, restart.
    guard = 0;
    while (if_d.hcount != 12'd700 && guard < 900) begin
      @(negedge clkRGB);
      guard++;
    end
    chk("stop.reached_h700", 32'(guard < 900), 1);
    chk("stop.hs_before", 32'(if_d.hs), 0);
    @(posedge clkRGB); #2 enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clkRGB);
      chk("stop.blk", 32'(if_d.blk), 1);
      chk("stop.hs", 32'(if_d.hs), 1);
      chk("stop.lineStart", 32'(if_d.lineStart), 0);
      chk("stop.frameStart", 32'(if_d.frameStart), 0);
      if (k > 0) chk("stop.hcount", 32'(if_d.hcount), 0);
    end
    @(posedge clkRGB); #2 enable = 1'b1;
    @(negedge clkRGB);
    chk("restart.frameStart", 32'(if_d.frameStart), 1);
    chk("restart.hcount", 32'(if_d.hcount), 0);
    chk("restart.vcount", 32'(if_d.vcount), 0);

    // Asynchronous reset between edges, mid-line.
    repeat (50) @(negedge clkRGB);
    @(posedge clkRGB); #3 resetn = 1'b0;
    #1;
    chk("arst.hcount", 32'(if_d.hcount), 0);
    chk("arst.blk", 32'(if_d.blk), 1);
    chk("arst.hs", 32'(if_d.hs), 1);
    chk("arst.lineStart", 32'(if_d.lineStart), 0);
    chk("arst.activeEarly", 32'(if_d.activeEarly), 0);
    chk("arst.s2.blk", 32'(if_2.blk), 1);
    chk("arst.s2.hs", 32'(if_2.hs), 0);
    chk("arst.s2.hcount", 32'(if_2.hcount), 0);
`ifdef VIDEO_TIMING_FRAMECOUNT_EN
    chk("arst.frameCount", 32'(if_0.frameCount), 0);
`endif
    repeat (2) @(negedge clkRGB);
    @(posedge clkRGB); #2 resetn = 1'b1;
    @(negedge clkRGB);
    chk("rerun.frameStart", 32'(if_d.frameStart), 1);
    repeat (3 * SFRAME + 20) @(negedge clkRGB);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
